// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: shared definitions for the bit-serial adder.
//   sa_state_e   - sequencer state encoding (IDLE/RUN/DONE)
//   SA_WIDTH_DEF - default operand/sum width
package serial_adder_pkg;

  localparam int unsigned SA_WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sa_state_e;

endpackage

// File: rtl/adder_1_bit.sv
// adder_1_bit: single-bit full adder cell.
// Ports:
//   a, b      - operand bits
//   carry_in  - incoming carry
//   sum       - a ^ b ^ carry_in
//   carry_out - carry generated into the next bit
module adder_1_bit (
  input  logic a,
  input  logic b,
  input  logic carry_in,
  output logic sum,
  output logic carry_out
);

  assign sum       = a ^ b ^ carry_in;
  assign carry_out = (a & b) | (carry_in & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// serial_adder: bit-serial WIDTH-bit adder built on one adder_1_bit cell.
// Operands are captured in parallel on an accepted start and shifted LSB-first
// through the cell, one bit per clock; the carry is registered between bits.
// Ports:
//   clk, rst_n  - clock, synchronous active-low reset
//   start       - request an addition (honoured only in IDLE)
//   a, b, cin   - operands and initial carry, captured on acceptance
//   busy        - high in RUN and DONE
//   done        - one-cycle pulse, sum/cout valid from this cycle
//   sum, cout   - registered result and final carry, held until next completion
//   ovf         - signed overflow flag (only when SERIAL_ADDER_OVF_EN is defined)
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = SA_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  sa_state_e state_q, state_d;

  logic [WIDTH-1:0] a_sh_q;
  logic [WIDTH-1:0] b_sh_q;
  logic [WIDTH-1:0] result_q;
  logic [WIDTH-1:0] result_d;
  logic [WIDTH-1:0] sum_q;
  logic [CNT_W-1:0] cnt_q;
  logic             carry_q;
  logic             cout_q;
  logic             cell_sum;
  logic             cell_cout;
  logic             last_bit;

  adder_1_bit u_cell (a_sh_q[0], b_sh_q[0], carry_q, cell_sum, cell_cout);

  assign last_bit = (state_q == RUN) && (cnt_q == CNT_LAST);

  // Shift the whole result register right and drop the new bit into the MSB;
  // after WIDTH shifts the first (LSB) bit has reached position 0.
  always_comb begin
    result_d           = result_q >> 1;
    result_d[WIDTH-1]  = cell_sum;
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (last_bit) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    busy = (state_q == RUN) || (state_q == DONE);
    done = (state_q == DONE);
  end

  // Datapath: operand shifters, carry flop, bit counter, result capture
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      result_q <= '0;
      sum_q    <= '0;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      cout_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            a_sh_q   <= a;
            b_sh_q   <= b;
            carry_q  <= cin;
            cnt_q    <= '0;
            result_q <= '0;
          end
        end
        RUN: begin
          result_q <= result_d;
          carry_q  <= cell_cout;
          a_sh_q   <= a_sh_q >> 1;
          b_sh_q   <= b_sh_q >> 1;
          if (last_bit) begin
            // Counter parks at zero rather than stepping past WIDTH-1.
            cnt_q  <= '0;
            sum_q  <= result_d;
            cout_q <= cell_cout;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;

`ifdef SERIAL_ADDER_OVF_EN
  logic ovf_q;

  // At the last bit carry_q is the carry into the MSB, cell_cout the carry out.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else if (last_bit) begin
      ovf_q <= carry_q ^ cell_cout;
    end
  end

  assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: directed self-checking bench for serial_adder (WIDTH=8).
// Define SERIAL_ADDER_OVF_EN to also exercise the overflow flag.
module tb_serial_adder;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
`ifdef SERIAL_ADDER_OVF_EN
  logic         ovf;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
`ifdef SERIAL_ADDER_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  // Wait (bounded) for done; c counts cycles since start was sampled.
  task automatic wait_done(inout int c, inout int nb);
    while (!done && c < 40) begin
      @(negedge clk);
      c++;
      if (busy) nb++;
    end
  endtask

  // One complete addition from IDLE, checking latency, busy length and result.
  task automatic run_add(input logic [W-1:0] av, input logic [W-1:0] bv, input logic ci,
                         input logic [W-1:0] es, input logic ec, input string tag);
    int c;
    int nb;
    @(negedge clk);
    a = av; b = bv; cin = ci; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = ~av; b = ~bv; cin = ~ci;  // operands must already be captured
    c  = 1;
    nb = busy ? 1 : 0;
    wait_done(c, nb);
    check({tag, "_latency"}, c, 9);
    check({tag, "_busy_cycles"}, nb, 9);
    check({tag, "_sum"}, sum, es);
    check({tag, "_cout"}, cout, ec);
    @(negedge clk);
    check({tag, "_done_pulse"}, done, 0);
    check({tag, "_idle"}, busy, 0);
  endtask

  initial begin
    int c;
    int nb;
    int npulse;
    int last_i;

    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_sum",  sum,  0);
    check("rst_cout", cout, 0);
`ifdef SERIAL_ADDER_OVF_EN
    check("rst_ovf", ovf, 0);
`endif
    rst_n = 1'b1;

    run_add(8'h5A, 8'h33, 1'b0, 8'h8D, 1'b0, "add_5a_33");
    run_add(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, "add_ff_01");
    run_add(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, "add_ff_ff_c");

    // start while busy is ignored
    @(negedge clk);
    a = 8'h10; b = 8'h20; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    a = 8'hAA; b = 8'h55;
    c = 1; nb = 1;
    repeat (4) begin @(negedge clk); c++; end
    start = 1'b0;
    wait_done(c, nb);
    check("ign_latency", c, 9);
    check("ign_sum", sum, 8'h30);
    npulse = 0;
    repeat (20) begin @(negedge clk); if (done) npulse++; end
    check("ign_extra_done", npulse, 0);
    check("ign_sum_hold", sum, 8'h30);

    // start held high: back-to-back operations
    @(negedge clk);
    a = 8'h01; b = 8'h01; cin = 1'b0; start = 1'b1;
    npulse = 0; last_i = -1;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (done) begin
        npulse++;
        check("held_sum", sum, 8'h02);
        if (last_i >= 0) check("held_gap", i - last_i, 10);
        else             check("held_first", i, 9);
        last_i = i;
      end
    end
    start = 1'b0;
    check("held_pulses", npulse, 3);
    repeat (12) @(negedge clk);

    // reset during RUN aborts and clears
    @(negedge clk);
    a = 8'h0F; b = 8'h01; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("abort_busy_before", busy, 1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_sum", sum, 8'h00);
    check("abort_cout", cout, 0);
    npulse = 0;
    repeat (15) begin @(negedge clk); if (done) npulse++; end
    check("abort_no_done", npulse, 0);
    run_add(8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, "after_abort");

`ifdef SERIAL_ADDER_OVF_EN
    run_add(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, "ovf_7f_01");
    check("ovf_7f_01_flag", ovf, 1);
    run_add(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, "ovf_80_80");
    check("ovf_80_80_flag", ovf, 1);
    run_add(8'h05, 8'h03, 1'b0, 8'h08, 1'b0, "ovf_05_03");
    check("ovf_05_03_flag", ovf, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Bit-serial WIDTH-bit adder built around one adder_1_bit instance.
- Operands are loaded in parallel and shifted LSB-first through the 1-bit cell, one bit per clock.
- carry_out is registered and fed back as carry_in on the next bit.
- Sits directly downstream of adder_1_bit as its sequencing stage, and upstream of any consumer of a full-width sum.

Parameters:
- WIDTH, 8, operand and sum width in bits; legal range 2..32.

Ports:
- clk  input  1  rising-edge clock; single clock domain.
- rst_n  input  1  synchronous, active-low reset.
- start  input  1  request a new addition; sampled only in IDLE.
- a  input  WIDTH  operand A; captured on an accepted start.
- b  input  WIDTH  operand B; captured on an accepted start.
- cin  input  1  initial carry; captured on an accepted start.
- busy  output  1  high while state is RUN or DONE.
- done  output  1  one-cycle pulse; sum/cout valid from this cycle.
- sum  output  WIDTH  result register, a+b+cin mod 2^WIDTH.
- cout  output  1  final carry (bit WIDTH of a+b+cin).

Behaviour:
- Reset (rst_n low at a rising edge), regardless of current state:
  - state=IDLE; busy=0, done=0, sum=0, cout=0.
  - Shift registers, carry flop and bit counter cleared.
- FSM has three states: IDLE, RUN, DONE.
  - IDLE: if start=1, capture a, b into shift registers, carry<=cin, cnt<=0, result<=0; go to RUN. Otherwise stay in IDLE.
  - RUN, each edge: the 1-bit cell sees a_sh[0], b_sh[0], carry.
    - result <= {cell.sum, result[WIDTH-1:1]}.
    - carry <= cell.carry_out.
    - a_sh, b_sh shift right by 1; cnt++.
    - When cnt==WIDTH-1, this is the last bit; go to DONE.
  - DONE: done=1 for exactly this cycle. sum=result and cout=carry are already registered and valid. Next edge returns to IDLE unconditionally.
- Latency:
  - start sampled at edge E; RUN occupies edges E+1..E+WIDTH.
  - done is high in the cycle after edge E+WIDTH, i.e. WIDTH+1 cycles after start is sampled.
  - Throughput: one add per WIDTH+2 cycles.
- sum/cout are updated only at the last RUN edge. They hold their value through IDLE until the next completion, and are not cleared by a new start.
- start while busy=1 (RUN or DONE) is ignored, with no queuing. a, b and cin may change freely after acceptance.
- start held high continuously: a new operation is accepted in the first IDLE cycle after DONE.
- Wrap-around: the sum is modulo 2^WIDTH; the overflow bit appears only on cout.
- Reset asserted mid-RUN aborts the operation, no done pulse is produced, and the sum is cleared to 0.
- cnt width: $clog2(WIDTH); it must never exceed WIDTH-1.

Optional Feature:
- Macro: SERIAL_ADDER_OVF_EN.
- Defined:
  - Adds output port ovf (1 bit), the signed two's-complement overflow flag.
  - ovf = carry into the MSB XOR carry out of the MSB. It is captured at the last RUN edge and is valid with done.
  - Reset value 0; holds like sum.
- Undefined: port absent; no extra flops.

Decomposition:
- Shared package/header serial_adder_pkg holds:
  - state encoding constants: IDLE=2'd0, RUN=2'd1, DONE=2'd2.
  - default width constant SA_WIDTH_DEF=8.
- Sub-module: exactly one instance of the existing adder_1_bit. Ports are connected in order: a, b, carry_in, sum, carry_out.
- No other sub-modules; FSM, shift registers and counter stay in serial_adder.

Test Plan:
- WIDTH=8, a=0x5A, b=0x33, cin=0, pulse start -> done exactly 9 cycles after start sampled; sum=0x8D, cout=0; busy high for 9 cycles.
- a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1. Then a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1.
- Start accepted with a=0x10, b=0x20; during RUN drive start=1 with a=0xAA, b=0x55 -> sum=0x30, one done pulse only; second request not executed.
- rst_n low for 1 cycle at the 4th RUN cycle of 0x0F+0x01 -> busy=0, done never pulses, sum=0x00, cout=0; a following start of 0x0F+0x01 gives 0x10.
- start held high for 30 cycles with a=0x01, b=0x01 -> done pulses every 10 cycles; sum=0x02 each time.
- With SERIAL_ADDER_OVF_EN: 0x7F+0x01 -> sum=0x80, cout=0, ovf=1; 0x80+0x80 -> sum=0x00, cout=1, ovf=1; 0x05+0x03 -> ovf=0.
